// File: rtl/xyf_ushift_reg.sv
// xyf_ushift_reg: parametrised universal shift register with rotate, clock
// enable and an autonomous burst-shift engine (START/BUSY/DONE handshake).
// Optional feature macro: XYF_PARITY_EN adds a registered parity output PAR.
// Note: "shift right" moves bits toward the MSB with DSR entering at Q[0];
// "shift left" moves bits toward the LSB with DSL entering at Q[WIDTH-1].
module xyf_ushift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             CE,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             DSR,
    input  logic             DSL,
    input  logic             ROT,
    input  logic             START,
    input  logic             DIR,
    input  logic [AMT_W-1:0] AMT,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE
`ifdef XYF_PARITY_EN
    ,
    output logic             PAR
`endif
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = AMT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic           busy_q, done_q;
    logic [W-1:0]   shr_c, shl_c;
`ifdef XYF_PARITY_EN
    logic           par_q;
`endif

    // Single-step shift candidates; ROT replaces the serial input with the end bit.
    always_comb begin
        shr_c = {q_q[W-2:0], (ROT ? q_q[W-1] : DSR)};
        shl_c = {(ROT ? q_q[0] : DSL), q_q[W-1:1]};
    end

    // Next-state and datapath: START beats S in IDLE; SHIFT and FIN ignore S/D/START.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    dir_d   = DIR;
                    cnt_d   = AMT;
                    state_d = (AMT == '0) ? ST_FIN : ST_SHIFT;
                end else begin
                    unique case (S)
                        2'b01:   q_d = shr_c;
                        2'b10:   q_d = shl_c;
                        2'b11:   q_d = D;
                        default: q_d = q_q;
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d   = dir_q ? shl_c : shr_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, data and registered status; everything freezes while CE is low.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (CE) begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= (state_d == ST_SHIFT);
            done_q  <= (state_d == ST_FIN);
        end
    end

`ifdef XYF_PARITY_EN
    // Parity of the next Q value so PAR tracks ^Q in the same cycle.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            par_q <= 1'b0;
        end else if (CE) begin
            par_q <= ^q_d;
        end
    end

    assign PAR = par_q;
`endif

    assign Q    = q_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_xyf_ushift_reg.sv
// Bench for xyf_ushift_reg (WIDTH=8, AMT_W=4): behavioural model plus
// directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_xyf_ushift_reg;

    localparam int unsigned W = 8;
    localparam int unsigned A = 4;

    logic          CP = 1'b0;
    logic          MR, CE, DSR, DSL, ROT, START, DIR;
    logic [1:0]    S;
    logic [W-1:0]  D;
    logic [A-1:0]  AMT;
    logic [W-1:0]  Q;
    logic          BUSY, DONE;
`ifdef XYF_PARITY_EN
    logic          PAR;
`endif

    int checks = 0;
    int errors = 0;

    xyf_ushift_reg #(.WIDTH(W), .AMT_W(A)) dut (
        .CP(CP), .MR(MR), .CE(CE), .S(S), .D(D), .DSR(DSR), .DSL(DSL),
        .ROT(ROT), .START(START), .DIR(DIR), .AMT(AMT),
        .Q(Q), .BUSY(BUSY), .DONE(DONE)
`ifdef XYF_PARITY_EN
        , .PAR(PAR)
`endif
    );

    always #5 CP = ~CP;

    // Model: register value, burst steps still to do, pending completion flag.
    int m_q    = 0;
    int m_left = 0;
    bit m_fin  = 1'b0;
    bit m_dir  = 1'b0;

    function automatic int step(input int v, input bit left, input bit rot,
                                input bit dsr, input bit dsl);
        if (!left) return ((v * 2) % 256) + (rot ? v / 128 : int'(dsr));
        return (v / 2) + 128 * (rot ? v % 2 : int'(dsl));
    endfunction

    always @(posedge CP or posedge MR) begin
        if (MR) begin
            m_q = 0; m_left = 0; m_fin = 1'b0; m_dir = 1'b0;
        end else if (CE) begin
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (m_left > 0) begin
                m_q = step(m_q, m_dir, ROT, DSR, DSL);
                m_left--;
                if (m_left == 0) m_fin = 1'b1;
            end else if (START) begin
                m_dir  = DIR;
                m_left = int'(AMT);
                if (m_left == 0) m_fin = 1'b1;
            end else begin
                case (S)
                    2'b01: m_q = step(m_q, 1'b0, ROT, DSR, DSL);
                    2'b10: m_q = step(m_q, 1'b1, ROT, DSR, DSL);
                    2'b11: m_q = int'(D);
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        S = 2'b11; D = v;
        tick();
        S = 2'b00;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (DONE) break;
            tick();
        end
        chk("burst_done_timeout", 32'(DONE), 32'd1);
    endtask

    initial begin
        int busy_cnt;
        MR = 1'b1; CE = 1'b1; S = 2'b00; D = '0; DSR = 1'b0; DSL = 1'b0;
        ROT = 1'b0; START = 1'b0; DIR = 1'b0; AMT = '0;

        // Per-cycle comparison of DUT against the model, on the falling edge.
        fork
            forever begin
                @(negedge CP);
                chk("model_Q", 32'(Q), 32'(m_q));
                chk("model_BUSY", 32'(BUSY), 32'(m_left > 0));
                chk("model_DONE", 32'(DONE), 32'(m_fin));
`ifdef XYF_PARITY_EN
                chk("model_PAR", 32'(PAR), 32'(^(8'(m_q))));
`endif
            end
        join_none

        #1;
        chk("reset_Q", 32'(Q), 32'h00);
        chk("reset_BUSY", 32'(BUSY), 32'd0);
        chk("reset_DONE", 32'(DONE), 32'd0);
        tick(); tick();
        MR = 1'b0;

        // Async reset mid-cycle, then a parallel load.
        load(8'hA5);
        chk("load_A5", 32'(Q), 32'hA5);
        #2 MR = 1'b1;
        #1;
        chk("async_mr_Q", 32'(Q), 32'h00);
        chk("async_mr_BUSY", 32'(BUSY), 32'd0);
        chk("async_mr_DONE", 32'(DONE), 32'd0);
        tick();
        MR = 1'b0;
        load(8'h3C);
        chk("load_3C", 32'(Q), 32'h3C);

        // Single-step shifts, plain and rotate.
        load(8'h81);
        S = 2'b01; DSR = 1'b0; ROT = 1'b0;
        tick(); tick();
        chk("shr2_81", 32'(Q), 32'h04);
        S = 2'b10; ROT = 1'b1;
        tick();
        chk("rotl_04", 32'(Q), 32'h02);
        S = 2'b00;

        // Rotate burst of 3; START wins over a same-cycle load; START during BUSY ignored.
        load(8'h96);
        START = 1'b1; DIR = 1'b0; AMT = 4'd3; ROT = 1'b1; S = 2'b11; D = 8'hFF;
        tick();
        START = 1'b0; S = 2'b00;
        chk("start_cycle_Q", 32'(Q), 32'h96);
        chk("burst3_busy1", 32'(BUSY), 32'd1);
        tick();
        chk("burst3_busy2", 32'(BUSY), 32'd1);
        START = 1'b1; DIR = 1'b1; AMT = 4'd7;
        tick();
        START = 1'b0;
        chk("burst3_busy3", 32'(BUSY), 32'd1);
        tick();
        chk("burst3_Q", 32'(Q), 32'hB4);
        chk("burst3_DONE", 32'(DONE), 32'd1);
        chk("burst3_BUSY_fin", 32'(BUSY), 32'd0);
        tick();
        chk("burst3_DONE_pulse", 32'(DONE), 32'd0);
        chk("burst3_no_queue", 32'(BUSY), 32'd0);

        // Zero-length burst.
        START = 1'b1; AMT = 4'd0;
        tick();
        START = 1'b0;
        chk("amt0_BUSY", 32'(BUSY), 32'd0);
        chk("amt0_DONE", 32'(DONE), 32'd1);
        chk("amt0_Q", 32'(Q), 32'hB4);
        tick();
        chk("amt0_DONE_end", 32'(DONE), 32'd0);

        // Burst of 5 left with fill, CE low two cycles mid-burst.
        ROT = 1'b0; DSL = 1'b1;
        load(8'h01);
        START = 1'b1; DIR = 1'b1; AMT = 4'd5;
        tick();
        START = 1'b0;
        busy_cnt = BUSY ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            if (!BUSY) break;
            CE = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            tick();
            if (BUSY) busy_cnt++;
        end
        chk("ce_burst_busy_len", 32'(busy_cnt), 32'd7);
        chk("ce_burst_Q", 32'(Q), 32'hF8);
        chk("ce_burst_DONE", 32'(DONE), 32'd1);
        CE = 1'b0;
        tick();
        chk("ce_fin_DONE_held", 32'(DONE), 32'd1);
        CE = 1'b1;
        tick();
        chk("ce_fin_DONE_end", 32'(DONE), 32'd0);

        // Reset mid-burst aborts without DONE.
        load(8'h01);
        START = 1'b1; DIR = 1'b1; AMT = 4'd5;
        tick();
        START = 1'b0;
        tick(); tick();
        #2 MR = 1'b1;
        #1;
        chk("abort_Q", 32'(Q), 32'h00);
        chk("abort_BUSY", 32'(BUSY), 32'd0);
        tick();
        MR = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_DONE", 32'(DONE), 32'd0);
        end

        // Bursts longer than WIDTH: rotate wraps, fill saturates.
        load(8'h96);
        ROT = 1'b1; START = 1'b1; DIR = 1'b1; AMT = 4'd10;
        tick();
        START = 1'b0;
        wait_done();
        chk("rot10_Q", 32'(Q), 32'hA5);
        tick();
        load(8'h00);
        ROT = 1'b0; DSR = 1'b1; START = 1'b1; DIR = 1'b0; AMT = 4'd15;
        tick();
        START = 1'b0;
        wait_done();
        chk("fill15_Q", 32'(Q), 32'hFF);
        tick();

`ifdef XYF_PARITY_EN
        load(8'h07);
        chk("par_07", 32'(PAR), 32'd1);
        load(8'h03);
        chk("par_03", 32'(PAR), 32'd0);
`endif

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
